uart_fpga_tx_fifo: RTL and testbench

UART_FPGA_TX_FIFO -- requirements
Module: uart_fpga_tx_fifo

---
 rtl/uart_fpga_pkg.sv | 29 ++
 rtl/uart_fpga_tx_fifo_if.sv | 18 +
 rtl/uart_fpga_sync_fifo.sv | 64 ++++++
 rtl/uart_fpga_tx_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_fpga_tx_fifo.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fpga_pkg.sv
// Shared definitions for the UART FPGA TX path: FSM encodings, parity modes and
// the reset baud divisor helper.
package uart_fpga_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic [1:0] ParityNone = 2'd0;
  localparam logic [1:0] ParityEven = 2'd1;
  localparam logic [1:0] ParityOdd  = 2'd2;

  localparam int unsigned DivWidth = 16;

  // Clamped to the same 2..65535 range the datapath accepts at run time.
  function automatic logic [DivWidth-1:0] reset_divisor(input int unsigned clk_hz,
                                                        input int unsigned baud);
    int unsigned div;
    div = (baud == 0) ? 2 : clk_hz / baud;
    if (div < 2) div = 2;
    if (div > 65535) div = 65535;
    return div[DivWidth-1:0];
  endfunction

endpackage

// File: rtl/uart_fpga_tx_fifo_if.sv
// Push/pop bundle between a UART datapath and its synchronous FIFO.
interface uart_fpga_tx_fifo_if #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) ();
  localparam int unsigned LvlW = $clog2(Depth) + 1;

  logic             push;
  logic [Width-1:0] wdata;
  logic             ready;
  logic             pop;
  logic [Width-1:0] rdata;
  logic             empty;
  logic [LvlW-1:0]  level;

  modport master (output push, wdata, pop, input ready, rdata, empty, level);
  modport slave  (input push, wdata, pop, output ready, rdata, empty, level);
endinterface

// File: rtl/uart_fpga_sync_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty/level; shared by TX and RX paths.
module uart_fpga_sync_fifo
  import uart_fpga_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  uart_fpga_tx_fifo_if.slave  fifo
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // Acceptance is judged on registered flags, so a same-cycle pop never frees a full FIFO.
  always_comb begin
    do_push  = fifo.push && !full_q;
    do_pop   = fifo.pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LvlW'(Depth));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= fifo.wdata;
  end

  assign fifo.ready = !full_q;
  assign fifo.empty = empty_q;
  assign fifo.level = level_q;
  assign fifo.rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_fpga_tx_fifo.sv
// UART transmitter fed by a synchronous FIFO; frame config is latched at each start bit
// and frames drain back-to-back while words are queued.
module uart_fpga_tx_fifo
  import uart_fpga_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY          = 50000000,
  parameter int unsigned UART_BAUD_RATE           = 9600,
  parameter int unsigned NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int unsigned FIFO_DEPTH               = 16
) (
  input  logic                                IN_CLOCK,
  input  logic                                IN_RESET,
  input  logic                                IN_TX_VALID,
  input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0] IN_TX_DATA,
  output logic                                OUT_TX_READY,
  input  logic [15:0]                         IN_BAUD_DIV,
  input  logic [1:0]                          IN_PARITY_MODE,
  input  logic                                IN_STOP_BITS,
  output logic                                OUT_TX_SERIAL,
  output logic                                OUT_TX_ACTIVE,
  output logic                                OUT_TX_DONE,
  output logic [$clog2(FIFO_DEPTH):0]         OUT_FIFO_LEVEL,
  output logic                                OUT_FIFO_EMPTY
);
  localparam int unsigned DataW   = NUM_OF_DATA_BITS_IN_PACK;
  localparam int unsigned BitIdxW = $clog2(DataW);
  localparam logic [DivWidth-1:0] ResetDiv = reset_divisor(CLOCK_FREQUENCY, UART_BAUD_RATE);

  uart_fpga_tx_fifo_if #(.Width(DataW), .Depth(FIFO_DEPTH)) fifo_bus ();

  uart_fpga_sync_fifo #(
    .Width (DataW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (IN_CLOCK),
    .rst_i (IN_RESET),
    .fifo  (fifo_bus)
  );

  tx_state_e            state_q, state_d;
  logic [DivWidth-1:0]  cnt_q, cnt_d, div_q, div_d, eff_div;
  logic [DataW-1:0]     shift_q, shift_d;
  logic [BitIdxW-1:0]   bit_idx_q, bit_idx_d;
  logic                 parity_en_q, parity_en_d, parity_bit_q, parity_bit_d;
  logic                 stop2_q, stop2_d, stop_idx_q, stop_idx_d;
  logic                 serial_q, serial_d, active_q, active_d, done_q, done_d;
  logic                 bit_end, last_stop, load_frame, fifo_pop;

  assign fifo_bus.push  = IN_TX_VALID;
  assign fifo_bus.wdata = IN_TX_DATA;
  assign fifo_bus.pop   = fifo_pop;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    div_d        = div_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    parity_en_d  = parity_en_q;
    parity_bit_d = parity_bit_q;
    stop2_d      = stop2_q;
    stop_idx_d   = stop_idx_q;
    serial_d     = serial_q;
    active_d     = active_q;
    done_d       = 1'b0;
    load_frame   = 1'b0;
    fifo_pop     = 1'b0;
    eff_div      = (IN_BAUD_DIV < 16'd2) ? 16'd2 : IN_BAUD_DIV;
    bit_end      = (cnt_q == div_q - 1'b1);
    last_stop    = (stop_idx_q == stop2_q);
    if (bit_end) cnt_d = '0;

    case (state_q)
      StIdle: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        active_d = 1'b0;
        if (!fifo_bus.empty) load_frame = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == BitIdxW'(DataW - 1)) begin
            stop_idx_d = 1'b0;
            if (parity_en_q) begin
              state_d  = StParity;
              serial_d = parity_bit_q;
            end else begin
              state_d  = StStop;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          serial_d   = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        // Raised one clock early so the registered pulse lands on the frame's last clock.
        if (last_stop && (cnt_q == div_q - 16'd2)) done_d = 1'b1;
        if (bit_end) begin
          if (!last_stop) begin
            stop_idx_d = 1'b1;
          end else if (!fifo_bus.empty) begin
            load_frame = 1'b1;
          end else begin
            state_d  = StIdle;
            serial_d = 1'b1;
            active_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        cnt_d    = '0;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase

    if (load_frame) begin
      fifo_pop     = 1'b1;
      shift_d      = fifo_bus.rdata;
      div_d        = eff_div;
      parity_en_d  = (IN_PARITY_MODE == ParityEven) || (IN_PARITY_MODE == ParityOdd);
      parity_bit_d = (^fifo_bus.rdata) ^ (IN_PARITY_MODE == ParityOdd);
      stop2_d      = IN_STOP_BITS;
      serial_d     = 1'b0;
      active_d     = 1'b1;
      state_d      = StStart;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      div_q        <= ResetDiv;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      stop2_q      <= 1'b0;
      stop_idx_q   <= 1'b0;
      serial_q     <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      parity_en_q  <= parity_en_d;
      parity_bit_q <= parity_bit_d;
      stop2_q      <= stop2_d;
      stop_idx_q   <= stop_idx_d;
      serial_q     <= serial_d;
      active_q     <= active_d;
      done_q       <= done_d;
    end
  end

  assign OUT_TX_READY   = fifo_bus.ready;
  assign OUT_FIFO_LEVEL = fifo_bus.level;
  assign OUT_FIFO_EMPTY = fifo_bus.empty;
  assign OUT_TX_SERIAL  = serial_q;
  assign OUT_TX_ACTIVE  = active_q;
  assign OUT_TX_DONE    = done_q;

endmodule

// File: tb/tb_uart_fpga_tx_fifo.sv
// Bench for uart_fpga_tx_fifo: a line monitor decodes every frame against a scoreboard
// of expected words and configs queued when the words are pushed.
module tb_uart_fpga_tx_fifo;
  import uart_fpga_pkg::*;

  localparam int unsigned Depth = 16;
  localparam int unsigned DataW = 8;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
    logic [1:0]  par;
    logic        stop2;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic        serial, active, done;

  frame_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     done_count = 0;
  int     gap_count = 0;
  int     frames_done = 0;
  bit     mon_busy = 1'b0;

  uart_fpga_tx_fifo_if #(.Width(DataW), .Depth(Depth)) bus ();

  assign bus.pop   = 1'b0;
  assign bus.rdata = '0;

  always #5 clk = ~clk;

  uart_fpga_tx_fifo dut (
    .IN_CLOCK       (clk),
    .IN_RESET       (rst),
    .IN_TX_VALID    (bus.push),
    .IN_TX_DATA     (bus.wdata),
    .OUT_TX_READY   (bus.ready),
    .IN_BAUD_DIV    (baud_div),
    .IN_PARITY_MODE (parity_mode),
    .IN_STOP_BITS   (stop_bits),
    .OUT_TX_SERIAL  (serial),
    .OUT_TX_ACTIVE  (active),
    .OUT_TX_DONE    (done),
    .OUT_FIFO_LEVEL (bus.level),
    .OUT_FIFO_EMPTY (bus.empty)
  );

  function automatic void build_bits(input frame_t f, output logic [15:0] bits, output int nb);
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
    nb = 9;
    if (f.par == 2'd1 || f.par == 2'd2) begin
      bits[nb] = (^f.data) ^ (f.par == 2'd2);
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (f.stop2) begin
      bits[nb] = 1'b1;
      nb++;
    end
  endfunction

  task automatic mon_frame();
    frame_t      f;
    logic [15:0] bits;
    logic        exp_bit, exp_done;
    int          nb, total;
    mon_busy = 1'b1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: start bit at %0t with empty scoreboard", $time);
      for (int i = 0; i < 2000 && serial === 1'b0; i++) @(negedge clk);
      mon_busy = 1'b0;
      return;
    end
    f = sb.pop_front();
    build_bits(f, bits, nb);
    total = nb * int'(f.div);
    for (int c = 1; c <= total; c++) begin
      if (c > 1) @(negedge clk);
      if (rst === 1'b1) begin
        sb.delete();
        mon_busy = 1'b0;
        return;
      end
      exp_bit  = bits[(c-1)/int'(f.div)];
      exp_done = (c == total);
      checks++;
      if (serial !== exp_bit) begin
        errors++;
        $display("FAIL frame_bit data=%h clk=%0d: serial=%b want %b", f.data, c, serial, exp_bit);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL frame_done data=%h clk=%0d: done=%b want %b", f.data, c, done, exp_done);
      end
      checks++;
      if (active !== 1'b1) begin
        errors++;
        $display("FAIL frame_active data=%h clk=%0d: active=%b want 1", f.data, c, active);
      end
    end
    frames_done++;
    mon_busy = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        sb.delete();
      end else if (serial === 1'b0) begin
        mon_frame();
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL idle_done at %0t: done=%b want 0", $time, done);
        end
        if (sb.size() > 0) gap_count++;
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_count++;

  initial begin : watchdog
    #600000;
    $display("FAIL global_timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int unsigned dv, input logic [1:0] p,
                              input logic s2);
    frame_t f;
    f.data = d;
    f.div = dv;
    f.par = p;
    f.stop2 = s2;
    sb.push_back(f);
  endtask

  task automatic drive(input logic [7:0] d);
    bus.push  = 1'b1;
    bus.wdata = d;
    step(1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((sb.size() != 0 || mon_busy || active === 1'b1) && n < max) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, n);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_line: serial=%b active=%b done=%b want 1 0 0", name, serial, active, done);
    end
    checks++;
    if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_fifo: level=%0d empty=%b ready=%b want 0 1 1", name, bus.level,
               bus.empty, bus.ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.push = 1'b0;
    bus.wdata = '0;
    baud_div = 16'd4;
    parity_mode = 2'd0;
    stop_bits = 1'b0;
    step(3);
    check_idle_outputs("reset");
    drive(8'h55);
    bus.push = 1'b0;
    check_idle_outputs("reset_push");
    rst = 1'b0;
    step(2);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_8n1();
    int d0;
    baud_div = 16'd4;
    parity_mode = 2'd0;
    stop_bits = 1'b0;
    d0 = done_count;
    expect_frame(8'hA5, 4, 2'd0, 1'b0);
    drive(8'hA5);
    bus.push = 1'b0;
    checks++;
    if (serial !== 1'b1 || bus.level !== 5'd1) begin
      errors++;
      $display("FAIL latency_k: serial=%b level=%0d want 1 1", serial, bus.level);
    end
    step(1);
    checks++;
    if (serial !== 1'b0 || active !== 1'b1 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL latency_k1: serial=%b active=%b level=%0d want 0 1 0", serial, active,
               bus.level);
    end
    wait_idle("8n1", 200);
    checks++;
    if (done_count != d0 + 1) begin
      errors++;
      $display("FAIL 8n1_done_count: %0d want %0d", done_count - d0, 1);
    end
  endtask

  task automatic test_parity();
    baud_div = 16'd4;
    stop_bits = 1'b1;
    parity_mode = 2'd1;
    expect_frame(8'h07, 4, 2'd1, 1'b1);
    drive(8'h07);
    bus.push = 1'b0;
    wait_idle("even", 200);
    parity_mode = 2'd2;
    expect_frame(8'h07, 4, 2'd2, 1'b1);
    drive(8'h07);
    bus.push = 1'b0;
    wait_idle("odd", 200);
    parity_mode = 2'd3;
    stop_bits = 1'b0;
    expect_frame(8'hE6, 4, 2'd0, 1'b0);
    drive(8'hE6);
    bus.push = 1'b0;
    wait_idle("mode3", 200);
  endtask

  task automatic test_back_to_back();
    int d0, g0;
    logic [7:0] w;
    baud_div = 16'd4;
    parity_mode = 2'd0;
    stop_bits = 1'b0;
    d0 = done_count;
    expect_frame(8'h3C, 4, 2'd0, 1'b0);
    drive(8'h3C);
    bus.push = 1'b0;
    step(2);
    g0 = gap_count;
    for (int i = 0; i < 17; i++) begin
      w = 8'(i * 13 + 1);
      if (i < 16) expect_frame(w, 4, 2'd0, 1'b0);
      drive(w);
      if (i == 15) begin
        checks++;
        if (bus.level !== 5'd16 || bus.ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready: level=%0d ready=%b want 16 0", bus.level, bus.ready);
        end
      end
    end
    bus.push = 1'b0;
    checks++;
    if (bus.level !== 5'd16 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_17th: level=%0d ready=%b want 16 0", bus.level, bus.ready);
    end
    wait_idle("burst", 2000);
    checks++;
    if (done_count != d0 + 17) begin
      errors++;
      $display("FAIL burst_done_count: %0d want %0d", done_count - d0, 17);
    end
    checks++;
    if (gap_count != g0) begin
      errors++;
      $display("FAIL burst_gap: %0d idle cycles between frames want 0", gap_count - g0);
    end
  endtask

  task automatic test_div_change();
    baud_div = 16'd4;
    parity_mode = 2'd0;
    stop_bits = 1'b0;
    expect_frame(8'h5A, 4, 2'd0, 1'b0);
    drive(8'h5A);
    expect_frame(8'hC3, 8, 2'd0, 1'b0);
    drive(8'hC3);
    bus.push = 1'b0;
    checks++;
    if (bus.level !== 5'd1 || serial !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_level: level=%0d serial=%b want 1 0", bus.level, serial);
    end
    step(8);
    baud_div = 16'd8;
    wait_idle("div_change", 400);
  endtask

  task automatic test_div_min();
    parity_mode = 2'd0;
    stop_bits = 1'b0;
    baud_div = 16'd0;
    expect_frame(8'h96, 2, 2'd0, 1'b0);
    drive(8'h96);
    bus.push = 1'b0;
    wait_idle("div0", 100);
    baud_div = 16'd1;
    parity_mode = 2'd1;
    expect_frame(8'h69, 2, 2'd1, 1'b0);
    drive(8'h69);
    bus.push = 1'b0;
    wait_idle("div1", 100);
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    baud_div = 16'd4;
    parity_mode = 2'd0;
    stop_bits = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_frame(8'(8'h81 + i), 4, 2'd0, 1'b0);
      drive(8'(8'h81 + i));
    end
    bus.push = 1'b0;
    checks++;
    if (bus.level !== 5'd4 || active !== 1'b1) begin
      errors++;
      $display("FAIL queued_level: level=%0d active=%b want 4 1", bus.level, active);
    end
    step(14);
    d0 = done_count;
    rst = 1'b1;
    step(1);
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    step(60);
    checks++;
    if (done_count != d0 || serial !== 1'b1) begin
      errors++;
      $display("FAIL abort_quiet: done pulses=%0d serial=%b want 0 1", done_count - d0, serial);
    end
    expect_frame(8'hE1, 4, 2'd0, 1'b0);
    drive(8'hE1);
    bus.push = 1'b0;
    wait_idle("after_reset", 200);
    checks++;
    if (done_count != d0 + 1) begin
      errors++;
      $display("FAIL after_reset_done: %0d want %0d", done_count - d0, 1);
    end
  endtask

  initial begin : main
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_div_change();
    test_div_min();
    test_reset_mid_frame();
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
